// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared definitions for the pipeline stall/flush controller.
//   - FSM state encoding (RUN / LOAD_STALL / MEM_WAIT / FLUSH)
//   - REG_ZERO constant ($zero never creates a dependency)
//   - default parameter values
//   - packed control word that carries the seven pipeline enables/flushes
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN_ENC        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL_ENC = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT_ENC   = 2'd2;
  localparam logic [1:0] ST_FLUSH_ENC      = 2'd3;

  typedef enum logic [1:0] {
    RUN        = ST_RUN_ENC,
    LOAD_STALL = ST_LOAD_STALL_ENC,
    MEM_WAIT   = ST_MEM_WAIT_ENC,
    FLUSH      = ST_FLUSH_ENC
  } ctrlState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_LOAD_STALL_CYCLES = 1;
  localparam int DEF_FLUSH_CYCLES      = 1;
  localparam int DEF_MEM_TIMEOUT       = 255;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic hazMuxCon;
    logic ifidFlush;
    logic idexFlush;
  } ctrl_t;

  // Canonical control words, field order as in ctrl_t.
  localparam ctrl_t CTRL_IDLE      = 7'b1111000; // everything advances
  localparam ctrl_t CTRL_FREEZE    = 7'b0000000; // whole pipe held for DMem
  localparam ctrl_t CTRL_LOADUSE   = 7'b0011100; // hold PC + IF/ID, bubble into EX
  localparam ctrl_t CTRL_BRANCH    = 7'b1111011; // redirect, kill IF/ID and ID/EX
  localparam ctrl_t CTRL_FLUSHTAIL = 7'b1111010; // extra IF/ID kill cycles

endpackage

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// hazard_detect: purely combinational condition terms for the stall controller.
//   IDRegRs/IDRegRt : source regs of the instruction in ID
//   EXRegRt         : destination of the load in EX
//   EXMemRead       : EX instruction is a load
//   DMemReq/DMemReady : data-memory handshake
//   loadUse         : ID consumes the result of the load currently in EX
//   memWait         : MEM has an access in flight that is not completing
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] IDRegRs,
  input  logic [4:0] IDRegRt,
  input  logic [4:0] EXRegRt,
  input  logic       EXMemRead,
  input  logic       DMemReq,
  input  logic       DMemReady,
  output logic       loadUse,
  output logic       memWait
);

  assign loadUse = EXMemRead && (EXRegRt != REG_ZERO) &&
                   ((EXRegRt == IDRegRs) || (EXRegRt == IDRegRt));
  assign memWait = DMemReq && !DMemReady;

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: central stall/flush sequencer for the 5-stage pipe.
// Priority: DMem wait (freeze) > taken branch (flush) > load-use (bubble).
// Outputs are Mealy so a stall lands in the same cycle its cause appears.
// Ports:
//   clk, reset (async, active high)
//   IDRegRs, IDRegRt, EXRegRt, EXMemRead : load-use detection inputs
//   BranchTaken                          : branch resolved taken in EX
//   DMemReq, DMemReady                   : data-memory handshake
//   PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite : pipeline register enables
//   HazMuxCon                            : zero ID control (bubble)
//   IFIDFlush, IDEXFlush                 : register clears
//   mem_timeout                          : sticky DMem watchdog flag
// Optional (macro STALL_PERF_CNT_EN): perf_clr input and 32-bit wrapping
//   counters perf_stall_cycles, perf_flushes, perf_mem_wait.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
  parameter int FLUSH_CYCLES      = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT       = DEF_MEM_TIMEOUT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IDRegRs,
  input  logic [4:0]  IDRegRt,
  input  logic [4:0]  EXRegRt,
  input  logic        EXMemRead,
  input  logic        BranchTaken,
  input  logic        DMemReq,
  input  logic        DMemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        HazMuxCon,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        mem_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_wait
`endif
);

  // The cycle that enters a multi-cycle sequence is already its first cycle,
  // so the counter is loaded with N-1 and the last cycle is the one at cnt==1.
  localparam logic [3:0] LS_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TO_MATCH  = 8'(MEM_TIMEOUT - 1);

  ctrlState_t state, nextState;
  logic [3:0] cnt, nextCnt;
  logic [7:0] wcnt;
  logic       loadUse, memWait, flushAccept;
  ctrl_t      ctrl;

  hazard_detect uHaz (
    .IDRegRs   (IDRegRs),
    .IDRegRt   (IDRegRt),
    .EXRegRt   (EXRegRt),
    .EXMemRead (EXMemRead),
    .DMemReq   (DMemReq),
    .DMemReady (DMemReady),
    .loadUse   (loadUse),
    .memWait   (memWait)
  );

  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    ctrl        = CTRL_IDLE;
    flushAccept = 1'b0;
    if (memWait) begin
      // Freeze everywhere; stall/flush counters hold until memory returns.
      ctrl = CTRL_FREEZE;
      if (state == RUN) nextState = MEM_WAIT;
    end else begin
      case (state)
        LOAD_STALL: begin
          ctrl = CTRL_LOADUSE;
          if (cnt <= 4'd1) begin
            nextState = RUN;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt - 4'd1;
          end
        end
        FLUSH: begin
          // EX holds a bubble here, so branch/load-use inputs are stale.
          ctrl = CTRL_FLUSHTAIL;
          if (cnt <= 4'd1) begin
            nextState = RUN;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt - 4'd1;
          end
        end
        default: begin
          // RUN, and the MEM_WAIT cycle where memory completes: evaluate the
          // current inputs as RUN would.
          nextState = RUN;
          nextCnt   = '0;
          if (BranchTaken) begin
            ctrl        = CTRL_BRANCH;
            flushAccept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              nextCnt   = FL_RELOAD;
              nextState = FLUSH;
            end
          end else if (loadUse) begin
            ctrl = CTRL_LOADUSE;
            if (LOAD_STALL_CYCLES > 1) begin
              nextCnt   = LS_RELOAD;
              nextState = LOAD_STALL;
            end
          end
        end
      endcase
    end
    // While reset is held the pipe sees plain run values, whatever the inputs.
    if (reset) begin
      ctrl        = CTRL_IDLE;
      flushAccept = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Watchdog: wcnt counts consecutive wait cycles already elapsed, so the
  // flag sets at the end of wait cycle number MEM_TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!memWait)              wcnt <= '0;
      else if (wcnt != 8'hFF)    wcnt <= wcnt + 8'd1;
      if (memWait && (wcnt == TO_MATCH)) mem_timeout <= 1'b1;
    end
  end

  assign PCWrite    = ctrl.pcWrite;
  assign IFIDWrite  = ctrl.ifidWrite;
  assign IDEXWrite  = ctrl.idexWrite;
  assign EXMEMWrite = ctrl.exmemWrite;
  assign HazMuxCon  = ctrl.hazMuxCon;
  assign IFIDFlush  = ctrl.ifidFlush;
  assign IDEXFlush  = ctrl.idexFlush;

`ifdef STALL_PERF_CNT_EN
  logic perfClrQ;
  logic perfClrRise;

  assign perfClrRise = perf_clr && !perfClrQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfClrQ          <= 1'b0;
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_mem_wait     <= '0;
    end else begin
      perfClrQ <= perf_clr;
      if (perfClrRise) begin
        perf_stall_cycles <= '0;
        perf_flushes      <= '0;
        perf_mem_wait     <= '0;
      end else begin
        if (!ctrl.pcWrite)     perf_stall_cycles <= perf_stall_cycles + 32'd1;
        if (flushAccept)       perf_flushes      <= perf_flushes + 32'd1;
        if (state == MEM_WAIT) perf_mem_wait     <= perf_mem_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. Two instances share stimulus:
//   dutA: LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2, MEM_TIMEOUT=8
//   dutB: LOAD_STALL_CYCLES=3, FLUSH_CYCLES=1, MEM_TIMEOUT=255
// Control words are {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,HazMuxCon,IFIDFlush,IDEXFlush}.
module tb_pipeline_stall_controller;

  localparam logic [31:0] IDLE = 32'h78; // 1111000
  localparam logic [31:0] FRZ  = 32'h00; // 0000000
  localparam logic [31:0] LU   = 32'h1C; // 0011100
  localparam logic [31:0] BR   = 32'h7B; // 1111011
  localparam logic [31:0] FLT  = 32'h7A; // 1111010

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IDRegRs, IDRegRt, EXRegRt;
  logic       EXMemRead, BranchTaken, DMemReq, DMemReady;
  logic [6:0] outA, outB;
  logic       toA, toB;
  logic [31:0] oA, oB;

  assign oA = {25'd0, outA};
  assign oB = {25'd0, outB};

`ifdef STALL_PERF_CNT_EN
  logic        perfClr;
  logic [31:0] aStall, aFl, aMw, bStall, bFl, bMw;
`endif

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dutA (
    .clk(clk), .reset(reset),
    .IDRegRs(IDRegRs), .IDRegRt(IDRegRt), .EXRegRt(EXRegRt), .EXMemRead(EXMemRead),
    .BranchTaken(BranchTaken), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .PCWrite(outA[6]), .IFIDWrite(outA[5]), .IDEXWrite(outA[4]), .EXMEMWrite(outA[3]),
    .HazMuxCon(outA[2]), .IFIDFlush(outA[1]), .IDEXFlush(outA[0]),
    .mem_timeout(toA)
`ifdef STALL_PERF_CNT_EN
    , .perf_clr(perfClr), .perf_stall_cycles(aStall), .perf_flushes(aFl), .perf_mem_wait(aMw)
`endif
  );

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .MEM_TIMEOUT(255)) dutB (
    .clk(clk), .reset(reset),
    .IDRegRs(IDRegRs), .IDRegRt(IDRegRt), .EXRegRt(EXRegRt), .EXMemRead(EXMemRead),
    .BranchTaken(BranchTaken), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .PCWrite(outB[6]), .IFIDWrite(outB[5]), .IDEXWrite(outB[4]), .EXMEMWrite(outB[3]),
    .HazMuxCon(outB[2]), .IFIDFlush(outB[1]), .IDEXFlush(outB[0]),
    .mem_timeout(toB)
`ifdef STALL_PERF_CNT_EN
    , .perf_clr(perfClr), .perf_stall_cycles(bStall), .perf_flushes(bFl), .perf_mem_wait(bMw)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                     input logic mr, input logic br, input logic rq, input logic rd);
    IDRegRs = rs; IDRegRt = rt; EXRegRt = ert;
    EXMemRead = mr; BranchTaken = br; DMemReq = rq; DMemReady = rd;
    #1;
  endtask

  // Advance to just past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef STALL_PERF_CNT_EN
    perfClr = 1'b0;
`endif
    // Reset held with a live load-use on the inputs: outputs must still idle.
    reset = 1'b1;
    drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_outA", oA, IDLE);
    chk("rst_outB", oB, IDLE);
    chk("rst_toA", 32'(toA), 32'd0);
    cyc();
    reset = 1'b0;
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_A", oA, IDLE);
    cyc();

    // Load-use on rs: A stalls one cycle, B three.
    drv(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_c0_A", oA, LU);
    chk("lu_c0_B", oB, LU);
    cyc();
    drv(5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_c1_A", oA, IDLE);
    chk("lu_c1_B", oB, LU);
    cyc();
    drv(5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_c2_B", oB, LU);
    cyc();
    drv(5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_c3_B", oB, IDLE);
    // $zero destination and non-matching / non-load cases never stall.
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_zero_A", oA, IDLE);
    chk("lu_zero_B", oB, IDLE);
    drv(5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_nomatch_A", oA, IDLE);
    drv(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_noload_B", oB, IDLE);
    cyc();

    // Load-use on rt held for 4 cycles: B restarts its stall back-to-back.
    for (int i = 0; i < 4; i++) begin
      drv(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("lu_rt%0d_A", i), oA, LU);
      chk($sformatf("lu_rt%0d_B", i), oB, LU);
      cyc();
    end
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_c4_A", oA, IDLE);
    chk("b2b_c4_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_c5_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_c6_B", oB, IDLE);
    cyc();

    // Branch: A flushes two cycles and ignores load-use in its FLUSH cycle.
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_c0_A", oA, BR);
    chk("br_c0_B", oB, BR);
    cyc();
    drv(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_c1_A", oA, FLT);
    chk("br_c1_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_c2_A", oA, IDLE);
    chk("br_c2_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_c3_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_c4_B", oB, IDLE);
    cyc();

    // DMem wait of 4 cycles with a pending load-use, released on ready.
    for (int i = 0; i < 4; i++) begin
      drv(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("mw%0d_A", i), oA, FRZ);
      chk($sformatf("mw%0d_B", i), oB, FRZ);
      cyc();
    end
    drv(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mw_rdy_A", oA, LU);
    chk("mw_rdy_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_post_A", oA, IDLE);
    chk("mw_post_B", oB, LU);
    chk("mw_to_A", 32'(toA), 32'd0);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_post2_B", oB, LU);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw_post3_B", oB, IDLE);
    cyc();

    // Watchdog: A (timeout 8) flags after its 8th wait cycle, B never does.
    for (int k = 1; k <= 20; k++) begin
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("wd%0d_toA", k), 32'(toA), (k >= 9) ? 32'd1 : 32'd0);
      if (k == 1 || k == 20) chk($sformatf("wd%0d_outA", k), oA, FRZ);
      cyc();
    end
    chk("wd_toB", 32'(toB), 32'd0);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("wd_rdy_A", oA, IDLE);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_sticky_A", 32'(toA), 32'd1);
    cyc();

    // Async reset while A sits in FLUSH with cnt==1.
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rf_c0_A", oA, BR);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rf_c1_A", oA, FLT);
    reset = 1'b1;
    #1;
    chk("rf_async_A", oA, IDLE);
    chk("rf_async_toA", 32'(toA), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk("rf_perf_stall", aStall, 32'd0);
    chk("rf_perf_fl", aFl, 32'd0);
    chk("rf_perf_mw", aMw, 32'd0);
`endif
    cyc();
    reset = 1'b0;
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("rf_after_A", oA, IDLE);
    chk("rf_after_B", oB, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
